// File: rtl/fpga_mem_subsys.sv
// Hart-side memory subsystem: registered-read instruction ROM, byte-maskable data RAM, LED MMIO register, halt latch.
// Define FPGA_MEM_HEARTBEAT_EN to drive the top LED pin from a free-running 24-bit heartbeat counter.
module fpga_mem_subsys #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter int          N_LEDS     = 8,
  parameter logic [31:0] LED_ADDR   = 32'h0001_0000,
  parameter              INIT_FILE  = "program.mem"
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_imem_req,
  input  logic [31:0]       i_imem_raddr,
  output logic              o_imem_valid,
  output logic [31:0]       o_imem_rdata,
  input  logic              i_dmem_ren,
  input  logic              i_dmem_wen,
  input  logic [31:0]       i_dmem_addr,
  input  logic [31:0]       i_dmem_wdata,
  input  logic [3:0]        i_dmem_mask,
  output logic              o_dmem_valid,
  output logic [31:0]       o_dmem_rdata,
  output logic              o_dmem_err,
  input  logic              i_halt,
  output logic              o_halted,
  output logic [N_LEDS-1:0] o_led
);
  localparam int          IW         = $clog2(IMEM_WORDS);
  localparam int          DW         = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);
  // ROM image is placed by the bitstream memory-init flow or a simulation backdoor.
  localparam unused_init_file = INIT_FILE;

  typedef enum logic {S_IDLE = 1'b0, S_RD_RESP = 1'b1} dstate_t;

  logic [31:0]       r_rom [IMEM_WORDS];
  logic [31:0]       r_ram [DMEM_WORDS];
  dstate_t           r_state;
  dstate_t           w_next_state;
  logic              r_imem_valid;
  logic [31:0]       r_imem_rdata;
  logic [31:0]       r_dmem_rdata;
  logic              r_err;
  logic              r_halted;
  logic [N_LEDS-1:0] r_led;

  logic [IW-1:0]     w_iidx;
  logic [DW-1:0]     w_didx;
  logic              w_wen, w_misalign, w_in_dmem, w_is_led, w_bad_addr;
  logic              w_ram_we, w_led_we, w_err_set;
  logic [31:0]       w_led_ext;
  logic [N_LEDS-1:0] w_led_next;
  logic              w_unused;

  assign w_iidx     = i_imem_raddr[IW+1:2];
  assign w_didx     = i_dmem_addr[DW+1:2];
  assign w_unused   = ^{i_imem_raddr[31:IW+2], i_imem_raddr[1:0]};

  // Halted harts cannot write; the write strobe is simply masked away.
  assign w_wen      = i_dmem_wen & ~r_halted;
  assign w_misalign = (i_dmem_addr[1:0] != 2'b00) & (|i_dmem_mask);
  assign w_in_dmem  = i_dmem_addr < DMEM_BYTES;
  assign w_is_led   = i_dmem_addr == LED_ADDR;
  assign w_bad_addr = w_misalign | ~(w_in_dmem | w_is_led);
  assign w_ram_we   = w_wen & ~w_bad_addr & w_in_dmem;
  assign w_led_we   = w_wen & ~w_bad_addr & w_is_led;
  assign w_err_set  = (i_dmem_ren & w_wen) | ((i_dmem_ren | w_wen) & w_bad_addr);

  always_comb begin
    w_led_ext = '0;
    w_led_ext[N_LEDS-1:0] = r_led;
    w_led_next = r_led;
    for (int i = 0; i < N_LEDS; i++) begin
      if (i_dmem_mask[i/8]) w_led_next[i] = i_dmem_wdata[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_mask[b]) r_ram[w_didx][8*b +: 8] <= i_dmem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_imem_valid <= 1'b0;
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
      r_err        <= 1'b0;
      r_halted     <= 1'b0;
      r_led        <= '0;
    end else begin
      r_imem_valid <= i_imem_req;
      if (i_imem_req) r_imem_rdata <= r_rom[w_iidx];
      if (i_dmem_ren) begin
        if (w_wen | w_bad_addr) r_dmem_rdata <= '0;
        else if (w_is_led)      r_dmem_rdata <= w_led_ext;
        else                    r_dmem_rdata <= r_ram[w_didx];
      end
      if (w_err_set) r_err    <= 1'b1;
      if (i_halt)    r_halted <= 1'b1;
      if (w_led_we)  r_led    <= w_led_next;
    end
  end

  // Data-port FSM: IDLE -> RD_RESP on a read, RD_RESP holds while reads keep arriving.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    w_next_state = i_dmem_ren ? S_RD_RESP : S_IDLE;
      S_RD_RESP: w_next_state = i_dmem_ren ? S_RD_RESP : S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_dmem_valid = (r_state == S_RD_RESP);
  end

  assign o_imem_valid = r_imem_valid;
  assign o_imem_rdata = r_imem_rdata;
  assign o_dmem_rdata = r_dmem_rdata;
  assign o_dmem_err   = r_err;
  assign o_halted     = r_halted;

`ifdef FPGA_MEM_HEARTBEAT_EN
  logic [23:0] r_hb;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_hb <= '0;
    else          r_hb <= r_hb + 24'd1;
  end
  always_comb begin
    o_led = r_led;
    o_led[N_LEDS-1] = r_hb[23];
  end
`else
  assign o_led = r_led;
`endif
endmodule

// File: tb/tb_fpga_mem_subsys.sv
// Self-checking bench for fpga_mem_subsys: directed scenarios plus a randomized data-port run against a reference model.
module tb_fpga_mem_subsys;
  localparam logic [31:0] LED_ADDR = 32'h0001_0000;
`ifdef FPGA_MEM_HEARTBEAT_EN
  localparam logic [7:0] LED_CHK = 8'h7F;
`else
  localparam logic [7:0] LED_CHK = 8'hFF;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req = 1'b0;
  logic [31:0] imem_raddr = '0;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        dmem_ren = 1'b0, dmem_wen = 1'b0;
  logic [31:0] dmem_addr = '0, dmem_wdata = '0;
  logic [3:0]  dmem_mask = '0;
  logic        dmem_valid, dmem_err, halt = 1'b0, halted;
  logic [31:0] dmem_rdata;
  logic [7:0]  led;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_rom [32];
  logic [31:0] m_ram [16];
  logic [7:0]  m_led;
  logic        m_err;
  logic [31:0] m_rdata;

  fpga_mem_subsys dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_imem_req(imem_req), .i_imem_raddr(imem_raddr),
    .o_imem_valid(imem_valid), .o_imem_rdata(imem_rdata),
    .i_dmem_ren(dmem_ren), .i_dmem_wen(dmem_wen), .i_dmem_addr(dmem_addr),
    .i_dmem_wdata(dmem_wdata), .i_dmem_mask(dmem_mask),
    .o_dmem_valid(dmem_valid), .o_dmem_rdata(dmem_rdata), .o_dmem_err(dmem_err),
    .i_halt(halt), .o_halted(halted), .o_led(led)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic dcycle(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask);
    dmem_ren = ren; dmem_wen = wen; dmem_addr = addr; dmem_wdata = wdata; dmem_mask = mask;
    @(posedge clk);
    #1;
    dmem_ren = 1'b0; dmem_wen = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    if (imem_valid !== 1'b0) begin n_err++; $display("FAIL reset_imem_valid got %h exp 0", imem_valid); end
    if (imem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_imem_rdata got %h exp 0", imem_rdata); end
    if (dmem_valid !== 1'b0) begin n_err++; $display("FAIL reset_dmem_valid got %h exp 0", dmem_valid); end
    if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_dmem_rdata got %h exp 0", dmem_rdata); end
    if (dmem_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %h exp 0", dmem_err); end
    if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %h exp 0", halted); end
    if ((led & LED_CHK) !== 8'h0) begin n_err++; $display("FAIL reset_led got %h exp 0", led); end
    n_vec += 7;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [31:0] prog [3];
    logic [31:0] last;
    int idx;
    prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093; prog[2] = 32'h0020_0113;
    for (int i = 0; i < 3; i++) dut.r_rom[i] = prog[i];
    for (int i = 0; i < 3; i++) begin
      imem_req = 1'b1; imem_raddr = 32'(i * 4);
      @(posedge clk); #1;
      if (imem_valid !== 1'b1) begin n_err++; $display("FAIL fetch_valid[%0d] got %h exp 1", i, imem_valid); end
      if (imem_rdata !== prog[i]) begin n_err++; $display("FAIL fetch_word[%0d] got %h exp %h", i, imem_rdata, prog[i]); end
      n_vec += 2;
    end
    imem_req = 1'b0;
    @(posedge clk); #1;
    if (imem_valid !== 1'b0) begin n_err++; $display("FAIL fetch_idle_valid got %h exp 0", imem_valid); end
    if (imem_rdata !== prog[2]) begin n_err++; $display("FAIL fetch_hold got %h exp %h", imem_rdata, prog[2]); end
    n_vec += 2;
    for (int i = 0; i < 32; i++) begin
      m_rom[i] = $urandom;
      dut.r_rom[i] = m_rom[i];
    end
    last = imem_rdata;
    for (int i = 0; i < 24; i++) begin
      logic req;
      req = ($urandom_range(0, 3) != 0);
      idx = $urandom_range(0, 31);
      imem_req = req;
      imem_raddr = 32'(idx * 4) + 32'($urandom_range(0, 3));
      @(posedge clk); #1;
      if (req) last = m_rom[idx];
      if (imem_valid !== req) begin n_err++; $display("FAIL fetch_rand_valid[%0d] got %h exp %h", i, imem_valid, req); end
      if (imem_rdata !== last) begin n_err++; $display("FAIL fetch_rand_word[%0d] got %h exp %h", i, imem_rdata, last); end
      n_vec += 2;
    end
    imem_req = 1'b0;
  endtask

  task automatic test_byte_write();
    dcycle(1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'hF);
    dcycle(1'b0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101);
    dcycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    if (dmem_valid !== 1'b1) begin n_err++; $display("FAIL bytewr_valid got %h exp 1", dmem_valid); end
    if (dmem_rdata !== 32'h11BB_33DD) begin n_err++; $display("FAIL bytewr_data got %h exp 11bb33dd", dmem_rdata); end
    @(posedge clk); #1;
    if (dmem_valid !== 1'b0) begin n_err++; $display("FAIL bytewr_valid_pulse got %h exp 0", dmem_valid); end
    if (dmem_err !== 1'b0) begin n_err++; $display("FAIL bytewr_err got %h exp 0", dmem_err); end
    n_vec += 4;
  endtask

  task automatic test_led();
    dcycle(1'b0, 1'b1, LED_ADDR, 32'h0000_00A5, 4'b0001);
    if ((led & LED_CHK) !== (8'hA5 & LED_CHK)) begin n_err++; $display("FAIL led_pin got %h exp a5", led); end
    dcycle(1'b1, 1'b0, LED_ADDR, 32'h0, 4'h0);
    if (dmem_rdata !== 32'h0000_00A5) begin n_err++; $display("FAIL led_readback got %h exp a5", dmem_rdata); end
    if (dmem_valid !== 1'b1) begin n_err++; $display("FAIL led_read_valid got %h exp 1", dmem_valid); end
    n_vec += 3;
  endtask

  task automatic test_errors();
    dcycle(1'b1, 1'b0, 32'h0002_0000, 32'h0, 4'h0);
    if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL err_oor_data got %h exp 0", dmem_rdata); end
    if (dmem_valid !== 1'b1) begin n_err++; $display("FAIL err_oor_valid got %h exp 1", dmem_valid); end
    if (dmem_err !== 1'b1) begin n_err++; $display("FAIL err_oor_flag got %h exp 1", dmem_err); end
    do_reset();
    if (dmem_err !== 1'b0) begin n_err++; $display("FAIL err_cleared got %h exp 0", dmem_err); end
    dcycle(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
    if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL err_rw_data got %h exp 0", dmem_rdata); end
    if (dmem_err !== 1'b1) begin n_err++; $display("FAIL err_rw_flag got %h exp 1", dmem_err); end
    dcycle(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    if (dmem_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL err_rw_written got %h exp cafef00d", dmem_rdata); end
    n_vec += 7;
  endtask

  task automatic test_halt();
    do_reset();
    dcycle(1'b0, 1'b1, LED_ADDR, 32'h0000_00A5, 4'b0001);
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set got %h exp 1", halted); end
    dcycle(1'b0, 1'b1, LED_ADDR, 32'h0000_005A, 4'b0001);
    if ((led & LED_CHK) !== (8'hA5 & LED_CHK)) begin n_err++; $display("FAIL halt_led_frozen got %h exp a5", led); end
    dcycle(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    dcycle(1'b0, 1'b1, 32'h0003_0000, 32'h1, 4'hF);
    if (halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky got %h exp 1", halted); end
    if (dmem_err !== 1'b0) begin n_err++; $display("FAIL halt_no_err got %h exp 0", dmem_err); end
    imem_req = 1'b1; imem_raddr = 32'h14;
    @(posedge clk); #1;
    imem_req = 1'b0;
    if (imem_rdata !== m_rom[5]) begin n_err++; $display("FAIL halt_fetch got %h exp %h", imem_rdata, m_rom[5]); end
    dcycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    if (dmem_rdata !== 32'h11BB_33DD) begin n_err++; $display("FAIL halt_read got %h exp 11bb33dd", dmem_rdata); end
    n_vec += 6;
  endtask

  task automatic test_reset_midread();
    dcycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    if (dmem_valid !== 1'b1) begin n_err++; $display("FAIL midrd_pre_valid got %h exp 1", dmem_valid); end
    #2 rst_n = 1'b0;
    #1;
    if (dmem_valid !== 1'b0) begin n_err++; $display("FAIL midrd_valid got %h exp 0", dmem_valid); end
    if ((led & LED_CHK) !== 8'h0) begin n_err++; $display("FAIL midrd_led got %h exp 0", led); end
    if (halted !== 1'b0) begin n_err++; $display("FAIL midrd_halted got %h exp 0", halted); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    dcycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    if (dmem_rdata !== 32'h11BB_33DD) begin n_err++; $display("FAIL midrd_ram_kept got %h exp 11bb33dd", dmem_rdata); end
    n_vec += 5;
  endtask

  task automatic test_random();
    do_reset();
    m_led = 8'h0; m_err = 1'b0; m_rdata = 32'h0;
    for (int w = 0; w < 16; w++) begin
      m_ram[w] = $urandom;
      dcycle(1'b0, 1'b1, 32'(w * 4), m_ram[w], 4'hF);
    end
    for (int i = 0; i < 300; i++) begin
      logic ren, wen, bad;
      logic [31:0] addr, wdata;
      logic [3:0] mask;
      int op, sel;
      op = $urandom_range(0, 9);
      ren = (op <= 3) || (op == 8);
      wen = (op >= 4 && op <= 8);
      sel = $urandom_range(0, 19);
      if (sel < 16)       addr = 32'(sel * 4);
      else if (sel < 18)  addr = LED_ADDR;
      else if (sel == 18) addr = 32'h0002_0000 + 32'($urandom_range(0, 255) * 4);
      else                addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      wdata = $urandom;
      mask = 4'($urandom_range(0, 15));
      bad = ((addr[1:0] != 2'b00) && (mask != 4'h0)) || !((addr < 32'd4096) || (addr == LED_ADDR));
      if (ren) begin
        if (wen || bad)            m_rdata = 32'h0;
        else if (addr == LED_ADDR) m_rdata = {24'h0, m_led};
        else                       m_rdata = m_ram[addr >> 2];
      end
      if (wen && !bad) begin
        if (addr == LED_ADDR) begin
          if (mask[0]) m_led = wdata[7:0];
        end else begin
          for (int b = 0; b < 4; b++)
            if (mask[b]) m_ram[addr >> 2][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      if ((ren && wen) || ((ren || wen) && bad)) m_err = 1'b1;
      dcycle(ren, wen, addr, wdata, mask);
      if (dmem_valid !== ren) begin n_err++; $display("FAIL rand_valid[%0d] got %h exp %h", i, dmem_valid, ren); end
      if (dmem_rdata !== m_rdata) begin n_err++; $display("FAIL rand_rdata[%0d] addr %h got %h exp %h", i, addr, dmem_rdata, m_rdata); end
      if (dmem_err !== m_err) begin n_err++; $display("FAIL rand_err[%0d] got %h exp %h", i, dmem_err, m_err); end
      if ((led & LED_CHK) !== (m_led & LED_CHK)) begin n_err++; $display("FAIL rand_led[%0d] got %h exp %h", i, led, m_led); end
      n_vec += 4;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte_write();
    test_led();
    test_errors();
    test_halt();
    test_reset_midread();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
